// File: rtl/hex_sr_ctrl_pkg.sv
// hex_sr_ctrl shared definitions
// state encoding, word width and default ring depth
package hex_sr_ctrl_pkg;

  localparam int WORD_W     = 6;
  localparam int LENGTH_DEF = 40;
  localparam int IDXW_DEF   = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    CIRC  = 2'd2
  } state_t;

endpackage

// File: rtl/hex_sr_ring_pos.sv
// hex_sr_ring_pos: modulo-LENGTH counter
// clear has priority over enable; wraps at LENGTH-1
module hex_sr_ring_pos #(
  parameter int LENGTH = 40,
  parameter int IDXW   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [IDXW-1:0] cnt
);

  localparam logic [IDXW-1:0] LAST = IDXW'(LENGTH - 1);

  // count up with explicit wrap at LENGTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + IDXW'(1);
      end
    end
  end

endmodule

// File: rtl/hex_sr_ctrl.sv
// hex_sr_ctrl: loader and random-index reader
// for the recirculating hex shift register ring
module hex_sr_ctrl
  import hex_sr_ctrl_pkg::*;
#(
  parameter int                LENGTH = LENGTH_DEF,
  parameter int                IDXW   = IDXW_DEF,
  parameter logic [WORD_W-1:0] FILL   = 6'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WORD_W-1:0] sr_data,
  output logic              sr_recirc,
  input  logic [WORD_W-1:0] sr_out_data,
  output logic              ring_valid,
  output logic              frame_start,
  output logic              underrun,
  input  logic              rd_req,
  input  logic [IDXW-1:0]   rd_idx,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [IDXW-1:0] LAST  = IDXW'(LENGTH - 1);
  localparam logic [IDXW:0]   LEN_X = (IDXW+1)'(LENGTH);

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   cnt;
  logic [IDXW-1:0]   pos;
  logic [IDXW-1:0]   rd_idx_q;
  logic              in_load;
  logic              in_circ;
  logic              load_done;
  logic              rd_acc;
  logic              rd_hit;

  assign in_load = (state == LOAD);
  assign in_circ = (state == CIRC);

  // last load word this cycle, not pre-empted
  assign load_done = in_load
                   && (cnt == LAST)
                   && !load_start;

  assign rd_acc = rd_req
               && in_circ
               && !rd_busy
               && ({1'b0, rd_idx} < LEN_X)
               && !load_start;

  // requested word is at the ring output
  assign rd_hit = rd_busy
               && (pos == rd_idx_q)
               && !load_start;

  hex_sr_ring_pos #(
    .LENGTH (LENGTH),
    .IDXW   (IDXW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_start),
    .en    (in_load),
    .cnt   (cnt)
  );

  hex_sr_ring_pos #(
    .LENGTH (LENGTH),
    .IDXW   (IDXW)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_done),
    .en    (in_circ),
    .cnt   (pos)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // next state and ring-side decodes
  always_comb begin
    state_nx    = state;
    sr_recirc   = 1'b1;
    sr_data     = FILL;
    din_ready   = 1'b0;
    frame_start = 1'b0;
    unique case (state)
      EMPTY: begin
        if (load_start) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        sr_recirc = 1'b0;
        din_ready = 1'b1;
        if (din_valid) begin
          sr_data = din;
        end
        if (load_start) begin
          state_nx = LOAD;
        end else if (cnt == LAST) begin
          state_nx = CIRC;
        end
      end
      CIRC: begin
        frame_start = (pos == '0);
        if (load_start) begin
          state_nx = LOAD;
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  // load status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_valid <= 1'b0;
      underrun   <= 1'b0;
    end else if (load_start) begin
      ring_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (load_done) begin
        ring_valid <= 1'b1;
      end
      if (in_load && !din_valid) begin
        underrun <= 1'b1;
      end
    end
  end

  // read tracking: accept, wait, capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy  <= 1'b0;
      rd_idx_q <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_hit;
      if (load_start) begin
        rd_busy <= 1'b0;
      end else if (rd_acc) begin
        rd_busy  <= 1'b1;
        rd_idx_q <= rd_idx;
      end else if (rd_hit) begin
        rd_busy <= 1'b0;
      end
      if (rd_hit) begin
        rd_data <= sr_out_data;
      end
    end
  end

endmodule

// File: tb/tb_hex_sr_ctrl.sv
// tb_hex_sr_ctrl: scoreboard bench with ring model
// directed load/read/cancel/reset scenarios
module tb_hex_sr_ctrl;

  localparam int L = hex_sr_ctrl_pkg::LENGTH_DEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic [5:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [5:0] sr_data;
  logic       sr_recirc;
  logic [5:0] sr_out_data;
  logic       ring_valid;
  logic       frame_start;
  logic       underrun;
  logic       rd_req = 1'b0;
  logic [5:0] rd_idx = '0;
  logic       rd_busy;
  logic       rd_valid;
  logic [5:0] rd_data;

  always #5 clk = ~clk;

  hex_sr_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sr_data     (sr_data),
    .sr_recirc   (sr_recirc),
    .sr_out_data (sr_out_data),
    .ring_valid  (ring_valid),
    .frame_start (frame_start),
    .underrun    (underrun),
    .rd_req      (rd_req),
    .rd_idx      (rd_idx),
    .rd_busy     (rd_busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  // stand-in for the external shift register ring
  logic [5:0] ring [L];
  assign sr_out_data = ring[L-1];

  always @(posedge clk) begin
    ring[0] <= sr_recirc ? ring[L-1] : sr_data;
    for (int i = 1; i < L; i++) ring[i] <= ring[i-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int d;
    int c;
  } exp_t;

  exp_t q[$];

  // monitor: every rd_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_valid_unexpected: got data %0d at cycle %0d want no pulse",
                 rd_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", int'(rd_data), e.d);
        chk("rd_cycle", cyc, e.c);
      end
    end
  end

  int c0 = 0;
  logic [5:0] expw [L];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input logic [L-1:0] vmask,
                      input bit rd_with_start, input int rd_at);
    int rdy;
    rdy = 0;
    load_start = 1'b1;
    if (rd_with_start) begin
      rd_req = 1'b1;
      rd_idx = 6'd4;
    end
    step();
    load_start = 1'b0;
    rd_req = 1'b0;
    chk("load_ring_valid_clr", int'(ring_valid), 0);
    chk("load_underrun_clr", int'(underrun), 0);
    chk("load_busy_clr", int'(rd_busy), 0);
    for (int k = 0; k < L; k++) begin
      din = 6'(base + k);
      din_valid = vmask[k];
      expw[k] = vmask[k] ? 6'(base + k) : 6'h00;
      rd_req = (k == rd_at);
      rd_idx = 6'd2;
      if (din_ready) rdy++;
      step();
    end
    din_valid = 1'b0;
    rd_req = 1'b0;
    c0 = cyc;
    chk("din_ready_cycles", rdy, L);
    chk("din_ready_circ", int'(din_ready), 0);
    chk("ring_valid_set", int'(ring_valid), 1);
    chk("underrun_after_load", int'(underrun), int'(vmask != '1));
    chk("first_word", int'(sr_out_data), int'(expw[0]));
    chk("first_frame", int'(frame_start), 1);
    chk("busy_after_load", int'(rd_busy), 0);
  endtask

  task automatic circ_check(input int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p = (cyc - c0) % L;
      chk("frame_start", int'(frame_start), int'(p == 0));
      chk("ring_word", int'(sr_out_data), int'(expw[p]));
      chk("recirc", int'(sr_recirc), 1);
      step();
    end
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < L && ((cyc - c0) % L) != p; i++) step();
  endtask

  task automatic do_read(input int idx);
    int p;
    exp_t e;
    p = (cyc - c0) % L;
    e.d = int'(expw[idx]);
    e.c = cyc + ((idx - p - 1 + L) % L) + 2;
    q.push_back(e);
    rd_req = 1'b1;
    rd_idx = 6'(idx);
    step();
    rd_req = 1'b0;
    chk("rd_busy_set", int'(rd_busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk("read_drain_pending", q.size(), 0);
    q.delete();
    chk("rd_busy_done", int'(rd_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] m;
    int hold;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ring_valid", int'(ring_valid), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_rd_busy", int'(rd_busy), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_recirc", int'(sr_recirc), 1);
    chk("rst_sr_data", int'(sr_data), 0);
    chk("rst_frame", int'(frame_start), 0);
    rst_n = 1'b1;
    step();

    // read in EMPTY is ignored
    rd_req = 1'b1;
    rd_idx = 6'd3;
    step();
    rd_req = 1'b0;
    chk("empty_rd_ignored", int'(rd_busy), 0);
    repeat (3) step();

    // full load, frame timing
    load(0, '1, 1'b0, -1);
    circ_check(81);

    // reads with short and maximal latency
    wait_pos(5);
    do_read(12);
    drain();
    do_read((cyc - c0) % L);
    drain();

    // out-of-range index ignored
    rd_req = 1'b1;
    rd_idx = 6'd40;
    step();
    rd_req = 1'b0;
    chk("idx40_ignored", int'(rd_busy), 0);
    repeat (45) step();

    // second request while busy ignored
    wait_pos(0);
    do_read(30);
    rd_req = 1'b1;
    rd_idx = 6'd2;
    step();
    rd_req = 1'b0;
    chk("busy_hold", int'(rd_busy), 1);
    drain();
    repeat (3) step();
    chk("rd_data_held", int'(rd_data), int'(expw[30]));
    chk("rd_valid_single", int'(rd_valid), 0);

    // request during LOAD ignored
    load(5, '1, 1'b0, 10);
    circ_check(45);

    // underrun in load cycles 3 and 7
    m = '1;
    m[3] = 1'b0;
    m[7] = 1'b0;
    load(10, m, 1'b0, -1);
    do_read(3);
    drain();
    do_read(7);
    drain();
    do_read(4);
    drain();
    chk("underrun_sticky", int'(underrun), 1);

    // load_start with rd_req in the same cycle
    load(20, '1, 1'b1, -1);
    repeat (45) step();
    chk("same_cycle_dropped", int'(rd_busy), 0);

    // load_start cancels a pending read
    wait_pos(0);
    rd_req = 1'b1;
    rd_idx = 6'd35;
    step();
    rd_req = 1'b0;
    chk("pending_busy", int'(rd_busy), 1);
    repeat (3) step();
    load(30, '1, 1'b0, -1);
    circ_check(45);
    do_read(17);
    drain();

    // asynchronous reset mid-load
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    din_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 6'(k);
      step();
    end
    chk("mid_load_ready", int'(din_ready), 1);
    #3;
    rst_n = 1'b0;
    #1;
    hold = 0;
    chk("arst_ring_valid", int'(ring_valid), 0);
    chk("arst_recirc", int'(sr_recirc), 1);
    chk("arst_ready", int'(din_ready), 0);
    chk("arst_sr_data", int'(sr_data), 0);
    din_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_state", int'(ring_valid) + hold, 0);
    load(0, '1, 1'b0, -1);
    circ_check(41);
    do_read(33);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_sr_ctrl.md
Name: hex_sr_ctrl

Overview:
- Upstream controller for the 6-bit-wide hex shift register ring (LENGTH stages).
- Drives the ring's data input and recirculate select, and loads exactly LENGTH words from a valid/ready source.
- After loading, keeps the ring recirculating and tracks which stored word is at the ring output.
- Serves random-index reads by waiting for the requested word to come round.

Parameters:
- LENGTH, 40: ring depth in words; must match the shift register instance.
- IDXW, 6: width of word index; must satisfy 2^IDXW >= LENGTH.
- FILL, 6'h00: word written into the ring on a load-cycle underrun.

Ports:
- clk  in  1  rising-edge clock, shared with the shift register.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse; begins a load of LENGTH words.
- din  in  6  load data word.
- din_valid  in  1  din holds a valid word this cycle.
- din_ready  out  1  high in every LOAD cycle (the ring shifts every clock).
- sr_data  out  6  to shift register data input.
- sr_recirc  out  1  to shift register recirculate select (1 = recirculate).
- sr_out_data  in  6  shift register output word.
- ring_valid  out  1  ring holds a complete load.
- frame_start  out  1  high in a CIRC cycle when ring position = 0.
- underrun  out  1  sticky; a LOAD cycle had din_valid=0.
- rd_req  in  1  read request pulse.
- rd_idx  in  IDXW  requested word index, 0..LENGTH-1.
- rd_busy  out  1  read pending.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  6  captured word.

Behaviour:
- States: EMPTY, LOAD, CIRC.
- Reset (async, rst_n=0) → EMPTY.
  - Registered outputs reset to: ring_valid=0, underrun=0, rd_busy=0, rd_valid=0, rd_data=0.
  - Internal: pos=0, load count=0.
- sr_recirc and sr_data are combinational decodes:
  - sr_recirc = 1 in EMPTY and CIRC, 0 in LOAD.
  - sr_data = din when in LOAD with din_valid=1, otherwise FILL.
  - In reset they therefore read sr_recirc=1, sr_data=FILL.
- Transitions:
  - load_start in any state → LOAD on the next edge; load count=0; ring_valid=0; underrun cleared.
  - load_start during LOAD restarts the count.
- LOAD:
  - Word k is driven on sr_data in load cycle k (k=0..LENGTH-1).
  - The count increments each cycle.
  - Any cycle with din_valid=0 writes FILL and sets underrun.
  - After cycle LENGTH-1 → CIRC; ring_valid=1; pos=0.
- CIRC:
  - Word k appears on sr_out_data in CIRC cycle k (mod LENGTH).
  - pos increments each cycle and wraps LENGTH-1 → 0.
  - frame_start = (state==CIRC && pos==0).
- Reads:
  - rd_req is accepted only if state==CIRC, rd_busy=0, and rd_idx<LENGTH. Otherwise it is ignored silently, with no rd_valid.
  - On acceptance, rd_idx is latched and rd_busy=1 from the next cycle.
  - Capture happens in the first cycle after acceptance in which pos==latched idx: sr_out_data is sampled and rd_busy cleared.
  - rd_valid pulses for 1 cycle on the following cycle, with rd_data held until the next capture.
  - Latency from rd_req cycle to rd_valid is 2..LENGTH+1 cycles. When rd_idx equals pos in the request cycle, latency is LENGTH+1.
- Simultaneous events:
  - load_start and rd_req in the same cycle: load wins and the read is dropped.
  - load_start while rd_busy: the read is cancelled, rd_busy clears, and no rd_valid is issued.
- Reset mid-LOAD or mid-read: returns to EMPTY with ring_valid=0; the ring contents are treated as invalid.
- Width rules:
  - pos and count are IDXW bits with an explicit wrap at LENGTH, not at 2^IDXW.
  - All data paths are 6 bits.

Decomposition:
- Shared package (or shared include for the Verilog build) holds:
  - state encoding: EMPTY=2'd0, LOAD=2'd1, CIRC=2'd2;
  - WORD_W=6;
  - the default LENGTH, shared with the shift register instance.
- One natural sub-module: hex_sr_ring_pos.
  - Modulo-LENGTH counter with clear and enable, used for both the load count and pos.

Test Plan:
1. Reset, then load_start and 40 cycles of din=k with valid=1 (LENGTH=40) → din_ready high for exactly 40 cycles; first CIRC cycle sr_out_data=0 with frame_start=1; frame_start repeats every 40 cycles; sr_recirc=1 throughout CIRC.
2. Read with pos=5 when rd_req arrives, rd_idx=12 → rd_valid 8 cycles later with rd_data=12. A second read with rd_idx=pos → rd_valid after 41 cycles.
3. din_valid low in load cycles 3 and 7 → ring words 3 and 7 read back as FILL=0; underrun=1 until the next load_start.
4. rd_req in EMPTY, rd_req during LOAD, rd_idx=40, and rd_req while rd_busy → all ignored, no rd_valid, no change in busy state.
5. load_start in the same cycle as rd_req, and load_start mid-read → read dropped, rd_busy falls, new load completes normally.
6. rst_n low mid-LOAD (cycle 20, asynchronously, between edges) → immediate EMPTY, ring_valid=0, sr_recirc=1; a full reload afterwards passes scenario 1.
